// File: rtl/draw_line_arbiter_pkg.sv
// Shared definitions for the draw-line arbiter and the other draw blocks.
package draw_line_arbiter_pkg;

    // Default coordinate width used by the draw blocks.
    localparam int CORDW_DEF = 16;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    // Signed screen coordinate.
    typedef logic signed [CORDW_DEF-1:0] coord_t;

endpackage

// File: rtl/draw_line_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after
// last_grant_i, wrapping around. Reusable by any shared engine.
module rr_pick #(
    parameter int REQS = 4,
    parameter int IDW  = $clog2(REQS)
) (
    input  logic [REQS-1:0] req_i,
    input  logic [IDW-1:0]  last_grant_i,
    output logic [IDW-1:0]  winner_o,
    output logic            valid_o
);

    logic [IDW-1:0] idx;

    // Scan offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int i = REQS; i >= 1; i--) begin
            idx = IDW'((int'(last_grant_i) + i) % REQS);
            if (req_i[idx]) begin
                winner_o = idx;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_line_arbiter.sv
// Round-robin scheduler sharing one line engine between REQS requesters.
// Handshake: a requester holds req high until it sees its one-cycle ack,
// at which point its endpoints are latched; its one-cycle req_done follows
// once the engine reports done. eng_start is a one-cycle pulse to the engine.
module draw_line_arbiter
    import draw_line_arbiter_pkg::*;
#(
    parameter int CORDW = 16,
    parameter int REQS  = 4,
    parameter int IDW   = $clog2(REQS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REQS-1:0]         req,
    input  logic [REQS*CORDW-1:0]   req_x0,
    input  logic [REQS*CORDW-1:0]   req_y0,
    input  logic [REQS*CORDW-1:0]   req_x1,
    input  logic [REQS*CORDW-1:0]   req_y1,
    output logic [REQS-1:0]         ack,
    output logic [REQS-1:0]         req_done,
    output logic                    eng_start,
    output logic signed [CORDW-1:0] eng_x0,
    output logic signed [CORDW-1:0] eng_y0,
    output logic signed [CORDW-1:0] eng_x1,
    output logic signed [CORDW-1:0] eng_y1,
    input  logic                    eng_done,
    output logic [IDW-1:0]          grant_id,
    output logic                    busy,
    output arb_state_e              dbg_state
);

    arb_state_e              state_q, state_d;
    logic [IDW-1:0]          grant_q, grant_d;
    logic [IDW-1:0]          last_grant_q, last_grant_d;
    logic [REQS-1:0]         ack_q, ack_d;
    logic [REQS-1:0]         done_q, done_d;
    logic                    start_q, start_d;
    logic                    busy_q, busy_d;
    logic signed [CORDW-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;

    logic [IDW-1:0]          win;
    logic                    win_valid;
    logic signed [CORDW-1:0] win_x0, win_y0, win_x1, win_y1;

    rr_pick #(
        .REQS (REQS),
        .IDW  (IDW)
    ) u_pick (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .winner_o     (win),
        .valid_o      (win_valid)
    );

    // Select the winner's endpoint slices.
    always_comb begin
        win_x0 = '0;
        win_y0 = '0;
        win_x1 = '0;
        win_y1 = '0;
        for (int i = 0; i < REQS; i++) begin
            if (win == IDW'(i)) begin
                win_x0 = req_x0[i*CORDW +: CORDW];
                win_y0 = req_y0[i*CORDW +: CORDW];
                win_x1 = req_x1[i*CORDW +: CORDW];
                win_y1 = req_y1[i*CORDW +: CORDW];
            end
        end
    end

    // Next-state and output logic; pulses default low every cycle.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ack_d        = '0;
        done_d       = '0;
        start_d      = 1'b0;
        busy_d       = busy_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    grant_d = win;
                    x0_d    = win_x0;
                    y0_d    = win_y0;
                    x1_d    = win_x1;
                    y1_d    = win_y1;
                    ack_d   = REQS'(1) << win;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                start_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // A done coinciding with our own start pulse is not trusted.
                if (eng_done && !start_q) begin
                    done_d       = REQS'(1) << grant_q;
                    last_grant_d = grant_q;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any line in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(REQS-1);
            ack_q        <= '0;
            done_q       <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            x0_q         <= '0;
            y0_q         <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
        end
    end

    assign ack       = ack_q;
    assign req_done  = done_q;
    assign eng_start = start_q;
    assign eng_x0    = x0_q;
    assign eng_y0    = y0_q;
    assign eng_x1    = x1_q;
    assign eng_y1    = y1_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_draw_line_arbiter.sv
// Directed bench for draw_line_arbiter with a simple engine model.
module tb_draw_line_arbiter;
    import draw_line_arbiter_pkg::*;

    localparam int CORDW = 16;
    localparam int REQS  = 4;
    localparam int IDW   = 2;

    logic                    clk;
    logic                    rst;
    logic [REQS-1:0]         req;
    logic [REQS*CORDW-1:0]   req_x0, req_y0, req_x1, req_y1;
    logic [REQS-1:0]         ack;
    logic [REQS-1:0]         req_done;
    logic                    eng_start;
    logic signed [CORDW-1:0] eng_x0, eng_y0, eng_x1, eng_y1;
    logic                    eng_done;
    logic [IDW-1:0]          grant_id;
    logic                    busy;
    arb_state_e              dbg_state;

    coord_t m_x0[REQS];
    coord_t m_y0[REQS];
    coord_t m_x1[REQS];
    coord_t m_y1[REQS];

    int vectors;
    int miscompares;

    draw_line_arbiter #(
        .CORDW (CORDW),
        .REQS  (REQS),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_x0    (req_x0),
        .req_y0    (req_y0),
        .req_x1    (req_x1),
        .req_y1    (req_y1),
        .ack       (ack),
        .req_done  (req_done),
        .eng_start (eng_start),
        .eng_x0    (eng_x0),
        .eng_y0    (eng_y0),
        .eng_x1    (eng_x1),
        .eng_y1    (eng_y1),
        .eng_done  (eng_done),
        .grant_id  (grant_id),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic set_slice(input int i, input coord_t x0, input coord_t y0,
                             input coord_t x1, input coord_t y1);
        m_x0[i] = x0;
        m_y0[i] = y0;
        m_x1[i] = x1;
        m_y1[i] = y1;
        req_x0[i*CORDW +: CORDW] = x0;
        req_y0[i*CORDW +: CORDW] = y0;
        req_x1[i*CORDW +: CORDW] = x1;
        req_y1[i*CORDW +: CORDW] = y1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait for a grant, check it, run the engine for 'delay' cycles, check completion.
    task automatic serve(input int exp_id, input int delay, input bit drop);
        logic [REQS-1:0] exp_oh;
        bit got;
        bit early;
        got    = 1'b0;
        early  = 1'b0;
        exp_oh = 4'b0001 << exp_id;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack !== 4'b0000) begin
                got = 1'b1;
                break;
            end
        end
        vectors++;
        if (!got) begin
            $display("FAIL grant_timeout: ack=%b, required ack for id %0d", ack, exp_id);
            miscompares++;
            return;
        end
        vectors++;
        if (ack !== exp_oh || grant_id !== IDW'(exp_id)) begin
            $display("FAIL grant: ack=%b grant_id=%0d, required ack=%b grant_id=%0d",
                     ack, grant_id, exp_oh, exp_id);
            miscompares++;
        end
        vectors++;
        if (busy !== 1'b1 || eng_start !== 1'b0 || req_done !== 4'b0000) begin
            $display("FAIL grant_flags: busy=%b eng_start=%b req_done=%b, required 1 0 0000",
                     busy, eng_start, req_done);
            miscompares++;
        end
        vectors++;
        if (eng_x0 !== m_x0[exp_id] || eng_y0 !== m_y0[exp_id] ||
            eng_x1 !== m_x1[exp_id] || eng_y1 !== m_y1[exp_id]) begin
            $display("FAIL endpoints: (%0d,%0d)->(%0d,%0d), required (%0d,%0d)->(%0d,%0d)",
                     eng_x0, eng_y0, eng_x1, eng_y1,
                     m_x0[exp_id], m_y0[exp_id], m_x1[exp_id], m_y1[exp_id]);
            miscompares++;
        end
        if (drop) req[exp_id] = 1'b0;
        @(negedge clk);
        vectors++;
        if (eng_start !== 1'b1 || ack !== 4'b0000) begin
            $display("FAIL start_pulse: eng_start=%b ack=%b, required 1 0000", eng_start, ack);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (eng_start !== 1'b0) begin
            $display("FAIL start_one_cycle: eng_start=%b, required 0", eng_start);
            miscompares++;
        end
        repeat (delay - 2) begin
            if (req_done !== 4'b0000 || busy !== 1'b1) early = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (early) begin
            $display("FAIL line_in_progress: req_done/busy changed before eng_done, required 0000/1");
            miscompares++;
        end
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        vectors++;
        if (req_done !== exp_oh || busy !== 1'b0 || dbg_state !== IDLE) begin
            $display("FAIL completion: req_done=%b busy=%b state=%0d, required %b 0 0",
                     req_done, busy, dbg_state, exp_oh);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (ack !== 4'b0000 || req_done !== 4'b0000 || eng_start !== 1'b0 || busy !== 1'b0 ||
            grant_id !== 2'd0 || eng_x0 !== 16'sd0 || eng_y1 !== 16'sd0 || dbg_state !== IDLE) begin
            $display("FAIL reset_values: ack=%b done=%b start=%b busy=%b gid=%0d x0=%0d y1=%0d st=%0d, required all 0",
                     ack, req_done, eng_start, busy, grant_id, eng_x0, eng_y1, dbg_state);
            miscompares++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        set_slice(2, 16'sd10, 16'sd20, 16'sd50, 16'sd5);
        @(negedge clk);
        req = 4'b0100;
        serve(2, 40, 1'b1);
        @(negedge clk);
        vectors++;
        if (req_done !== 4'b0000 || busy !== 1'b0) begin
            $display("FAIL done_cleared: req_done=%b busy=%b, required 0000 0", req_done, busy);
            miscompares++;
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < REQS; i++)
            set_slice(i, coord_t'(100 + i), coord_t'(200 + i), coord_t'(-300 - i), coord_t'(-(i + 1)));
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < REQS; i++) serve(i, 3, 1'b1);
    endtask

    task automatic test_fairness();
        do_reset();
        req = 4'b0101;
        serve(0, 3, 1'b0);
        serve(2, 3, 1'b0);
        serve(0, 4, 1'b0);
        serve(2, 2, 1'b0);
        req = 4'b0000;
    endtask

    task automatic test_negative();
        set_slice(1, -16'sd5, -16'sd3, 16'sd7, -16'sd1);
        @(negedge clk);
        req = 4'b0010;
        serve(1, 5, 1'b1);
        vectors++;
        if (eng_x0 !== 16'hFFFB || eng_y1 !== 16'hFFFF) begin
            $display("FAIL negative_coords: eng_x0=%h eng_y1=%h, required fffb ffff", eng_x0, eng_y1);
            miscompares++;
        end
    endtask

    task automatic test_spurious_done();
        set_slice(3, 16'sd1, 16'sd2, 16'sd3, 16'sd4);
        @(negedge clk);
        req = 4'b0000;
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        vectors++;
        if (req_done !== 4'b0000 || busy !== 1'b0 || ack !== 4'b0000 || dbg_state !== IDLE) begin
            $display("FAIL spurious_idle: req_done=%b busy=%b ack=%b state=%0d, required 0000 0 0000 0",
                     req_done, busy, ack, dbg_state);
            miscompares++;
        end
        req = 4'b1000;
        @(negedge clk);
        vectors++;
        if (ack !== 4'b1000 || dbg_state !== START) begin
            $display("FAIL spurious_grant: ack=%b state=%0d, required 1000 1", ack, dbg_state);
            miscompares++;
        end
        req = 4'b0000;
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        vectors++;
        if (eng_start !== 1'b1 || req_done !== 4'b0000 || busy !== 1'b1 || dbg_state !== WAIT) begin
            $display("FAIL spurious_start: start=%b req_done=%b busy=%b state=%0d, required 1 0000 1 2",
                     eng_start, req_done, busy, dbg_state);
            miscompares++;
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (dbg_state !== WAIT || req_done !== 4'b0000) begin
            $display("FAIL spurious_still_wait: state=%0d req_done=%b, required 2 0000", dbg_state, req_done);
            miscompares++;
        end
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        vectors++;
        if (req_done !== 4'b1000 || busy !== 1'b0) begin
            $display("FAIL spurious_real_done: req_done=%b busy=%b, required 1000 0", req_done, busy);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_wait();
        set_slice(0, 16'sd11, 16'sd12, 16'sd13, 16'sd14);
        set_slice(1, -16'sd21, 16'sd22, -16'sd23, 16'sd24);
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        repeat (10) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || dbg_state !== WAIT) begin
            $display("FAIL pre_abort: busy=%b state=%0d, required 1 2", busy, dbg_state);
            miscompares++;
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || ack !== 4'b0000 || req_done !== 4'b0000 || eng_start !== 1'b0 ||
            dbg_state !== IDLE) begin
            $display("FAIL async_abort: busy=%b ack=%b done=%b start=%b state=%0d, required 0 0000 0000 0 0",
                     busy, ack, req_done, eng_start, dbg_state);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0011;
        serve(0, 3, 1'b1);
        serve(1, 3, 1'b1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req         = '0;
        req_x0      = '0;
        req_y0      = '0;
        req_x1      = '0;
        req_y1      = '0;
        eng_done    = 1'b0;
        for (int i = 0; i < REQS; i++) begin
            m_x0[i] = '0;
            m_y0[i] = '0;
            m_x1[i] = '0;
            m_y1[i] = '0;
        end

        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_negative();
        test_spurious_done();
        test_reset_mid_wait();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
